// File: rtl/lotr_pkg.sv
// Shared definitions for the UART receive front end and the uart_io command parser:
// receiver state encoding, command opcode characters and bit-level helpers.
package lotr_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } t_uart_rx_state;

    localparam logic [7:0] UART_ASCII_W = 8'h57;
    localparam logic [7:0] UART_ASCII_R = 8'h52;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line, falling-edge detect and bit-sample source.
// UART_RX_MAJORITY_EN: o_bit is a 2-of-3 vote over three consecutive synced samples.
module uart_rx_sync
    import lotr_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic i_rx,
    output logic o_line,
    output logic o_fall,
    output logic o_bit
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resync stages plus one cycle of history, preset to the idle-high line level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_line = r_sync;
    assign o_fall = r_prev & ~r_sync;

`ifdef UART_RX_MAJORITY_EN
    logic r_prev2;

    // Second history stage feeding the three-sample vote
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev2 <= 1'b1;
        end else begin
            r_prev2 <= r_prev;
        end
    end

    assign o_bit = maj3(r_sync, r_prev, r_prev2);
`else
    assign o_bit = r_sync;
`endif

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start qualification, mid-bit sampling, optional even parity,
// stop check and a one-entry holding register with valid/ready. Option: UART_RX_MAJORITY_EN.
module uart_rx_deser
    import lotr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2083,
    parameter int N_DATA_BITS  = 8,
    parameter int LSB_FIRST    = 0,
    parameter int PARITY_EN    = 0,
    parameter int N_STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_overrun,
    input  logic       rx_err_clr,
    output logic       rx_busy
);

    localparam int             CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  C_ONE       = CW'(1'b1);
    localparam logic [CW-1:0]  C_FULL      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  C_HALF      = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     C_LAST_BIT  = 3'(N_DATA_BITS - 1);
    localparam logic           C_LAST_STOP = 1'(N_STOP_BITS - 1);

    t_uart_rx_state r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_bit_cnt;
    logic           r_stop_cnt;
    logic [7:0]     r_shift;
    logic           r_par_bad;
    logic           r_stop_bad;
    logic           r_busy;

    logic [7:0]     r_data;
    logic           r_valid;
    logic           r_frame_err;
    logic           r_parity_err;
    logic           r_overrun;

    logic           w_line;
    logic           w_fall;
    logic           w_bit;
    logic [7:0]     w_shift_next;
    logic           w_done;
    logic           w_fe_set;
    logic           w_pe_set;
    logic           w_ov_set;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .i_rx   (uart_rx),
        .o_line (w_line),
        .o_fall (w_fall),
        .o_bit  (w_bit)
    );

    // Next shift-register value; bits above N_DATA_BITS stay zero in both orders
    always_comb begin
        w_shift_next = 8'h00;
        if (LSB_FIRST != 0) begin
            w_shift_next                = {1'b0, r_shift[7:1]};
            w_shift_next[N_DATA_BITS-1] = w_bit;
        end else begin
            w_shift_next = {r_shift[6:0], w_bit};
        end
    end

    assign w_done   = (r_state == STOP) && (r_cnt == C_FULL) && (r_stop_cnt == C_LAST_STOP);
    assign w_fe_set = w_done & (r_stop_bad | ~w_bit);
    assign w_pe_set = w_done & r_par_bad;
    assign w_ov_set = w_done & r_valid & ~rx_ready;

    // Frame FSM: bit timing, sampling and shift register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_shift    <= 8'h00;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        if (w_bit) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= DATA;
                            r_bit_cnt  <= 3'd0;
                            r_stop_cnt <= 1'b0;
                            r_shift    <= 8'h00;
                            r_par_bad  <= 1'b0;
                            r_stop_bad <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                DATA: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                            end else begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                PARITY: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt     <= '0;
                        r_par_bad <= even_parity(r_shift) ^ w_bit;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                STOP: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt <= '0;
                        if (r_stop_cnt == C_LAST_STOP) begin
                            // Leave at mid stop bit so a back-to-back start edge is not missed
                            if (r_stop_bad | ~w_bit) begin
                                r_state <= WAIT_IDLE;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                            r_stop_bad <= r_stop_bad | ~w_bit;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (w_line) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Holding register handshake and sticky error flags (a same-cycle set beats clear)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data       <= 8'h00;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_done) begin
                if (!r_valid || rx_ready) begin
                    r_data <= r_shift;
                end
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
            r_frame_err  <= w_fe_set | (r_frame_err  & ~rx_err_clr);
            r_parity_err <= w_pe_set | (r_parity_err & ~rx_err_clr);
            r_overrun    <= w_ov_set | (r_overrun    & ~rx_err_clr);
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_frame_err  = r_frame_err;
    assign rx_parity_err = r_parity_err;
    assign rx_overrun    = r_overrun;
    assign rx_busy       = r_busy;

endmodule
